// File: rtl/alu_pkg.sv
// Shared ALU definitions: MIPS shift funct codes, the decoded-shift control
// struct, and the decode function used by the execute stage.
package alu_pkg;

  localparam int N  = 32;
  localparam int SW = $clog2(N);

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  typedef struct packed {
    logic          left;
    logic          logical;
    logic [SW-1:0] amount;
    logic          illegal;
  } shift_dec_t;

  // Immediate shifts take the amount from shamt; variable shifts from the low
  // SW bits of rs (upper bits are architecturally ignored).
  function automatic shift_dec_t decode_shift(input logic [5:0]    funct,
                                              input logic [4:0]    shamt_field,
                                              input logic [SW-1:0] rs_amt);
    shift_dec_t d;
    d.left    = 1'b0;
    d.logical = 1'b1;
    d.amount  = shamt_field[SW-1:0];
    d.illegal = 1'b0;
    case (funct)
      F_SLL:  d.left = 1'b1;
      F_SRL:  ;
      F_SRA:  d.logical = 1'b0;
      F_SLLV: begin d.left = 1'b1; d.amount = rs_amt; end
      F_SRLV: d.amount = rs_amt;
      F_SRAV: begin d.logical = 1'b0; d.amount = rs_amt; end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shifter.sv
// Combinational barrel shifter.
//   in      : value to shift
//   amount  : shift distance
//   left    : 1 = shift left, 0 = shift right
//   logical : for right shifts, 1 = zero fill, 0 = sign fill
//   out     : shifted value
module shifter #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  in,
  input  logic [SW-1:0] amount,
  input  logic          left,
  input  logic          logical,
  output logic [N-1:0]  out
);

  logic signed [N-1:0] in_s;

  always_comb begin
    in_s = in;
    out  = '0;
    if (left)         out = in << amount;
    else if (logical) out = in >> amount;
    else              out = N'(in_s >>> amount);
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage execute front end for MIPS shift ops with valid/ready flow control.
// D register holds the decoded op; R register holds the shifted result.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : request handshake (in_ready independent of in_valid)
//   funct, shamt_field    : instruction fields
//   rs_val, rt_val, dest  : operands and destination register
//   out_valid/out_ready   : result handshake
//   result, out_dest      : shifted value and its destination
//   illegal               : funct was not a shift (result forced to 0)
module shift_exec_stage
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [5:0]   funct,
  input  logic [4:0]   shamt_field,
  input  logic [N-1:0] rs_val,
  input  logic [N-1:0] rt_val,
  input  logic [4:0]   dest,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [4:0]   out_dest,
  output logic         illegal
);

  logic         d_valid, r_valid;
  logic         r_adv, d_adv, accept;
  shift_dec_t   dec, d_ctl;
  logic [N-1:0] d_rt, sh_out;
  logic [4:0]   d_dest;

  assign r_adv    = !r_valid || out_ready;
  assign d_adv    = d_valid && r_adv;
  // D can take a new op when empty or when its current op moves to R.
  assign in_ready = !d_valid || r_adv;
  assign accept   = in_valid && in_ready;

  assign dec = decode_shift(funct, shamt_field, rs_val[SW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid <= 1'b0;
    end else if (accept) begin
      d_valid <= 1'b1;
    end else if (d_adv) begin
      d_valid <= 1'b0;
    end
  end

  // Data side of D needs no reset; d_valid qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      d_ctl  <= dec;
      d_rt   <= rt_val;
      d_dest <= dest;
    end
  end

  shifter #(.N(N), .SW(SW)) u_shifter (
    .in      (d_rt),
    .amount  (d_ctl.amount),
    .left    (d_ctl.left),
    .logical (d_ctl.logical),
    .out     (sh_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      result   <= '0;
      out_dest <= '0;
      illegal  <= 1'b0;
    end else if (r_adv) begin
      r_valid <= d_valid;
      if (d_valid) begin
        result   <= d_ctl.illegal ? '0 : sh_out;
        out_dest <= d_dest;
        illegal  <= d_ctl.illegal;
      end
    end
  end

  assign out_valid = r_valid;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage: reset, shift kinds, throughput,
// backpressure, illegal funct and reset during a stall.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, illegal;
  logic [5:0]  funct;
  logic [4:0]  shamt_field, dest, out_dest;
  logic [31:0] rs_val, rt_val, result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_exec_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .shamt_field(shamt_field),
    .rs_val(rs_val), .rt_val(rt_val), .dest(dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_dest(out_dest), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] d);
    in_valid = 1'b1; funct = f; shamt_field = sh; rs_val = rs; rt_val = rt; dest = d;
  endtask

  int acc;
  logic fire;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    funct = '0; shamt_field = '0; rs_val = '0; rt_val = '0; dest = '0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_illegal",   {31'b0, illegal},   32'd0);
    check("rst_out_dest",  {27'b0, out_dest},  32'd0);
    step(); step();
    rst_n = 1'b1;

    // SLL shamt 4: visible after the second edge
    drive(6'b000000, 5'd4, 32'h0, 32'h0000_00F1, 5'd3);
    step();
    in_valid = 1'b0;
    check("sll_not_yet", {31'b0, out_valid}, 32'd0);
    step();
    check("sll_valid",  {31'b0, out_valid}, 32'd1);
    check("sll_result", result,             32'h0000_0F10);
    check("sll_dest",   {27'b0, out_dest},  32'd3);
    check("sll_legal",  {31'b0, illegal},   32'd0);
    step();
    check("sll_drained", {31'b0, out_valid}, 32'd0);

    // SRAV then SRLV by rs low bits (amount 8)
    drive(6'b000111, 5'd0, 32'hFFFF_FFE8, 32'h8000_1234, 5'd5);
    step();
    drive(6'b000110, 5'd0, 32'hFFFF_FFE8, 32'h8000_1234, 5'd6);
    step();
    in_valid = 1'b0;
    check("srav_result", result,            32'hFF80_0012);
    check("srav_dest",   {27'b0, out_dest}, 32'd5);
    step();
    check("srlv_result", result,            32'h0080_0012);
    check("srlv_dest",   {27'b0, out_dest}, 32'd6);
    step();

    // 8 back-to-back SLLV ops: 1 << i, dest 8+i
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(6'b000100, 5'd0, 32'(i), 32'h1, 5'(8 + i));
      else       in_valid = 1'b0;
      step();
      if (i >= 1 && i <= 8) begin
        check($sformatf("b2b_valid%0d", i - 1),  {31'b0, out_valid}, 32'd1);
        check($sformatf("b2b_result%0d", i - 1), result,             32'h1 << (i - 1));
        check($sformatf("b2b_dest%0d", i - 1),   {27'b0, out_dest},  32'(7 + i));
      end
    end
    check("b2b_empty", {31'b0, out_valid}, 32'd0);

    // Backpressure: out_ready low for 5 cycles, SRL by 4*(k+1)
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(6'b000010, 5'(4 * (acc + 1)), 32'h0, 32'hF000_0000, 5'(20 + acc));
      fire = in_ready;
      step();
      if (fire) acc++;
      if (out_valid) check($sformatf("bp_stable%0d", c), result, 32'h0F00_0000);
    end
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_dest0",    {27'b0, out_dest}, 32'd20);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", {31'b0, in_ready}, 32'd1);
    step();
    check("bp_drain1_valid", {31'b0, out_valid}, 32'd1);
    check("bp_drain1",       result,             32'h00F0_0000);
    check("bp_drain1_dest",  {27'b0, out_dest},  32'd21);
    step();
    check("bp_empty", {31'b0, out_valid}, 32'd0);

    // Illegal funct, then SRA by 0
    drive(6'b100000, 5'd3, 32'h0, 32'h0000_1234, 5'd9);
    step();
    drive(6'b000011, 5'd0, 32'h0, 32'h8000_0000, 5'd10);
    step();
    in_valid = 1'b0;
    check("ill_flag",   {31'b0, illegal}, 32'd1);
    check("ill_result", result,           32'd0);
    step();
    check("sra0_result", result,           32'h8000_0000);
    check("sra0_legal",  {31'b0, illegal}, 32'd0);
    step();

    // Reset while D and R are full and stalled
    out_ready = 1'b0;
    drive(6'b000000, 5'd1, 32'h0, 32'h0000_0003, 5'd1);
    step();
    drive(6'b000000, 5'd2, 32'h0, 32'h0000_0003, 5'd2);
    step();
    in_valid = 1'b0;
    check("stall_full", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    {31'b0, out_valid}, 32'd0);
    check("mid_rst_result",   result,             32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready},  32'd1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_empty", {31'b0, out_valid}, 32'd0);
    step();
    check("post_rst_empty2", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
# shift_exec_stage

Pipelined execute-stage front end for MIPS shift instructions. Accepts decoded shift ops (SLL/SRL/SRA/SLLV/SRLV/SRAV) with operands over a valid/ready handshake, derives the shift amount and direction/logical controls, drives one combinational `shifter` instance, and registers the result toward writeback. Two-stage pipeline at full throughput with backpressure. Sits between register read/decode and the EX/MEM boundary.

## Interface
- `N`, 32, datapath width; shift-amount width `SW = $clog2(N)`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  stage accepts request this cycle.
- `funct`  in  6  MIPS funct field.
- `shamt_field`  in  5  instruction shamt field (immediate shifts).
- `rs_val`  in  N  shift-amount source for variable shifts.
- `rt_val`  in  N  value to shift.
- `dest`  in  5  destination register number.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  N  shifted value.
- `out_dest`  out  5  `dest` carried with the result.
- `illegal`  out  1  funct was not a shift op; qualified by `out_valid`.

## Operation
- Legal funct: SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111; anything else illegal.
- Stage 1 (decode register, D): on accept latch `rt_val`, `dest`, and decoded controls: `left` = SLL/SLLV; `logical` = SRL/SRLV (and SLL/SLLV, don't-care); amount = `shamt_field[SW-1:0]` for immediate, `rs_val[SW-1:0]` for variable (upper bits of `rs_val` ignored); `illegal` flag.
- Stage 2 (result register, R): D drives the `shifter` instance; on advance R latches shifter output (or 0 when illegal), `dest`, `illegal`.
- SRA/SRAV: arithmetic, sign bit `rt_val[N-1]` replicated. Amount 0: result = `rt_val`.
- Handshake: transfer on `valid && ready`. `out_valid`/`result`/`out_dest`/`illegal` stable while `out_valid && !out_ready`. `in_ready` must not depend on `in_valid`.
- `r_adv = !r_valid || out_ready`; `d_adv = d_valid && r_adv`; `in_ready = !d_valid || r_adv`.
- Simultaneous accept and drain in the same cycle: both occur; no bubble.
- D full and R stalled: `in_ready` = 0; D holds.

## Timing
- Latency: accepted at edge k -> `out_valid` with result after edge k+1 (2 register stages). Throughput 1/cycle with `out_ready` held high.
- Reset (async assert, any cycle, including mid-stall): `d_valid`, `r_valid` -> 0; `out_valid` 0, `result` 0, `out_dest` 0, `illegal` 0; `in_ready` 1 immediately after reset. In-flight ops discarded. Deassertion synchronous in usage (first accept on first edge after `rst_n` high).
- Data registers need not reset except outputs listed above; valid bits must.
- No combinational path from `in_*` to `out_*`. `in_ready` combinationally depends on `out_ready` (one level).

## Structure
- Shared package `alu_pkg`: funct localparams (`F_SLL`, `F_SRL`, `F_SRA`, `F_SLLV`, `F_SRLV`, `F_SRAV`) and a packed decoded-shift struct {left, logical, amount, illegal}.
- One sub-module: the existing `shifter` (parameter `N`), instantiated once between D and R. Decode is a function in `alu_pkg`, not a module.

## Test plan
- Reset mid-stall: fill D and R with `out_ready`=0, pulse `rst_n` low -> `out_valid`=0, `result`=0, `in_ready`=1 same cycle.
- SLL shamt 4, `rt_val`=0x0000_00F1 -> `result`=0x0000_0F10, `out_valid` two edges after accept.
- SRAV `rs_val`=0xFFFF_FFE8 (amount 8), `rt_val`=0x8000_1234 -> 0xFF80_0012; SRLV same -> 0x0080_0012.
- Back-to-back 8 ops, `out_ready`=1 -> 8 results on 8 consecutive cycles, order and `out_dest` preserved.
- Backpressure: `out_ready`=0 for 5 cycles with `in_valid`=1 -> exactly 2 accepted, `in_ready`=0 after, `result` stable; release -> drain in order, no loss/duplication.
- Illegal funct 100000, `rt_val`=0x1234 -> `illegal`=1, `result`=0; shamt 0 SRA 0x8000_0000 -> 0x8000_0000.
